// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
//   Shared constants for the RV32I multicycle control unit:
//     - FSM state encodings (IF, ID, EX, MEM, WB, HALT)
//     - major opcode constants for the supported instruction classes
//     - funct3 / funct7 field values used by the decoder
//     - ALUCtrl encodings understood by the datapath ALU
//     - alu_from_funct3(): shared funct3 -> ALU operation mapping used for
//       both register-register and register-immediate arithmetic
// -----------------------------------------------------------------------------
package ctrl_pkg;

  // FSM state encodings. HALT is only reachable when illegal-instruction
  // trapping is compiled in.
  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // funct3 values (instr[14:12]).
  localparam logic [2:0] F3_ADD = 3'b000;  // add/sub/addi
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;  // srl/sra/srli/srai
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;  // word load/store
  localparam logic [2:0] F3_BEQ = 3'b000;

  // funct7 values (instr[31:25]); ALT selects sub/sra.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALUCtrl encodings.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Result of the funct3 lookup: the ALU operation plus whether funct3
  // names an operation this core implements at all (sltu is not).
  typedef struct packed {
    logic [3:0] op;
    logic       ok;
  } alu_sel_t;

  // alt selects the alternate form of funct3 000 (sub) and 101 (sra).
  // The caller decides when alt may be honoured for each opcode.
  function automatic alu_sel_t alu_from_funct3(input logic [2:0] funct3,
                                               input logic       alt);
    alu_sel_t s;
    s.ok = 1'b1;
    case (funct3)
      F3_ADD:  s.op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  s.op = ALU_SLL;
      F3_SLT:  s.op = ALU_SLT;
      F3_XOR:  s.op = ALU_XOR;
      F3_SR:   s.op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   s.op = ALU_OR;
      F3_AND:  s.op = ALU_AND;
      default: begin
        s.op = ALU_ADD;
        s.ok = 1'b0;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Combinational instruction decoder for the multicycle control unit.
//   Classifies the instruction, selects the ALU operation and operand source,
//   and flags any encoding outside the supported RV32I subset.
//
// Ports
//   opcode      in   7  instr[6:0]
//   funct3      in   3  instr[14:12]
//   funct7      in   7  instr[31:25] (bit 5 picks sub/sra; the rest must be 0)
//   alu_ctrl    out  4  ALU operation for EX/MEM/WB
//   alu_src     out  1  ALU op2 = immediate
//   is_alu      out  1  R-type or I-type arithmetic
//   is_load     out  1  lw
//   is_store    out  1  sw
//   is_branch   out  1  beq
//   unsupported out  1  encoding lies outside the decoded RV32I subset
// -----------------------------------------------------------------------------
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       alu_src,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       unsupported
);

  logic     alt;
  alu_sel_t sel;

  // instr[30] only distinguishes sub from add for R-type; for immediates
  // that bit belongs to the immediate, except on the right-shift form.
  assign alt = funct7[5] & ((opcode == OP_R) | (funct3 == F3_SR));
  assign sel = alu_from_funct3(funct3, alt);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // through the block leaves one unassigned, which would infer a latch.
    alu_ctrl    = ALU_ADD;
    alu_src     = 1'b0;
    is_alu      = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    unsupported = 1'b1;

    case (opcode)
      OP_R: begin
        is_alu   = 1'b1;
        alu_ctrl = sel.op;
        // funct7 must be all-zero, or 0x20 on the two ops that have an
        // alternate form (sub, sra).
        unsupported = !sel.ok ||
                      !((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == F3_ADD) || (funct3 == F3_SR))));
      end

      OP_I: begin
        is_alu   = 1'b1;
        alu_src  = 1'b1;
        alu_ctrl = sel.op;
        // Shift immediates carry funct7 in the upper immediate bits; other
        // immediates use those bits as plain immediate data.
        case (funct3)
          F3_SLL:  unsupported = (funct7 != F7_BASE);
          F3_SR:   unsupported = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          default: unsupported = !sel.ok;
        endcase
      end

      OP_LW: begin
        is_load     = 1'b1;
        alu_src     = 1'b1;
        alu_ctrl    = ALU_ADD;
        unsupported = (funct3 != F3_W);
      end

      OP_SW: begin
        is_store    = 1'b1;
        alu_src     = 1'b1;
        alu_ctrl    = ALU_ADD;
        unsupported = (funct3 != F3_W);
      end

      OP_BEQ: begin
        is_branch   = 1'b1;
        alu_src     = 1'b0;
        alu_ctrl    = ALU_SUB;
        unsupported = (funct3 != F3_BEQ);
      end

      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for the RV32I multicycle datapath. Sequences each instruction
//   through IF -> ID -> EX -> (MEM) -> (WB) and drives the datapath strobes.
//   Outputs are combinational from the state, the held instruction word and
//   the handshake inputs that end a state (Zero in BEQ EX, mem_ready in MEM).
//
//   Parameter MEM_WAIT_MAX : cycles allowed in MEM before progress is forced
//                            (0 = wait forever for mem_ready).
//   Macro ILLEGAL_TRAP_EN  : when defined, an unsupported instruction sets the
//                            sticky illegal flag and parks the FSM in HALT
//                            until rst; when undefined it retires as a NOP and
//                            illegal is tied low.
//
// Ports
//   clk         in   1   clock
//   rst         in   1   synchronous active-high reset
//   instr       in   32  current instruction, stable from ID to next IF
//   instr_valid in   1   instruction memory returned instr this cycle
//   mem_ready   in   1   data memory completed the access this cycle
//   Zero        in   1   ALU zero flag
//   ifetch      out  1   instruction fetch request (IF)
//   PCSrc       out  1   PC takes branch target
//   ALUSrc      out  1   ALU op2 = immediate
//   RegWrite    out  1   register file write enable
//   MemToReg    out  1   writeback data from memory
//   MemRead     out  1   data memory read strobe
//   MemWrite    out  1   data memory write strobe
//   ALUCtrl     out  4   ALU operation
//   loadPC      out  1   one-cycle PC update, once per retired instruction
//   illegal     out  1   sticky illegal-instruction flag
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        Zero,
  output logic        ifetch,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        illegal
);

  // The counter only has to reach MEM_WAIT_MAX-1: that value marks the last
  // permitted MEM cycle.
  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LAST =
    CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          mem_done;

  logic [3:0]    dec_alu_ctrl;
  logic          dec_alu_src;
  logic          is_alu;
  logic          is_load;
  logic          is_store;
  logic          is_branch;
  logic          unsupported;

  // Register and immediate fields are consumed by the datapath, not here.
  logic          unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  alu_decoder u_dec (
    .opcode      (instr[6:0]),
    .funct3      (instr[14:12]),
    .funct7      (instr[31:25]),
    .alu_ctrl    (dec_alu_ctrl),
    .alu_src     (dec_alu_src),
    .is_alu      (is_alu),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_branch   (is_branch),
    .unsupported (unsupported)
  );

  // A timed-out access completes exactly like one acknowledged by memory.
  assign mem_done = mem_ready ||
                    ((MEM_WAIT_MAX > 0) && (wait_cnt == WAIT_LAST));

  // ---------------------------------------------------------------------------
  // State and MEM wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= ST_IF;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Held at zero outside MEM, so it is clear on every MEM entry.
      if (state == ST_MEM) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if ((state == ST_ID) && unsupported) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IF: begin
        if (instr_valid) state_nxt = ST_ID;
      end

      ST_ID: begin
        if (unsupported) begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = ST_HALT;
`else
          state_nxt = ST_IF;
`endif
        end else begin
          state_nxt = ST_EX;
        end
      end

      ST_EX: begin
        if (is_load || is_store) begin
          state_nxt = ST_MEM;
        end else if (is_branch) begin
          state_nxt = ST_IF;
        end else begin
          state_nxt = ST_WB;
        end
      end

      ST_MEM: begin
        if (mem_done) state_nxt = is_load ? ST_WB : ST_IF;
      end

      ST_WB: state_nxt = ST_IF;

`ifdef ILLEGAL_TRAP_EN
      ST_HALT: state_nxt = ST_HALT;
`endif

      default: state_nxt = ST_IF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ifetch   = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUCtrl  = ALU_AND;
    loadPC   = 1'b0;

    case (state)
      ST_IF: ifetch = 1'b1;

      ST_ID: begin
`ifndef ILLEGAL_TRAP_EN
        // Unsupported instruction retires here as a NOP.
        loadPC = unsupported;
`endif
      end

      ST_EX: begin
        ALUSrc  = dec_alu_src;
        ALUCtrl = dec_alu_ctrl;
        if (is_branch) begin
          loadPC = 1'b1;
          PCSrc  = Zero;
        end
      end

      // ALU controls stay at their EX values so the address/result the
      // datapath is using does not move under the memory or the regfile.
      ST_MEM: begin
        ALUSrc   = dec_alu_src;
        ALUCtrl  = dec_alu_ctrl;
        MemRead  = is_load;
        MemWrite = is_store;
        loadPC   = is_store && mem_done;
      end

      ST_WB: begin
        ALUSrc   = dec_alu_src;
        ALUCtrl  = dec_alu_ctrl;
        RegWrite = 1'b1;
        MemToReg = is_load;
        loadPC   = 1'b1;
      end

      default: ;
    endcase

    // Reset aborts whatever is in flight: nothing may commit in that cycle.
    if (rst) begin
      PCSrc    = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUCtrl  = ALU_AND;
      loadPC   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. A table of directed vectors with
//   hand-computed expectations, hand-written reset/trap sequences, and random
//   instructions drawn from a mnemonic table whose per-instruction behaviour
//   (cycle count, strobe counts, ALU op) is predicted by a small model.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int MAX_WAIT = 16;
  localparam int RUN_LIMIT = 80;

  // Instruction classes used by the bench model.
  localparam int C_ALU = 0;
  localparam int C_LW  = 1;
  localparam int C_SW  = 2;
  localparam int C_BEQ = 3;
  localparam int C_BAD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        Zero;
  logic        ifetch;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        illegal;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .Zero        (Zero),
    .ifetch      (ifetch),
    .PCSrc       (PCSrc),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .MemToReg    (MemToReg),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .ALUCtrl     (ALUCtrl),
    .loadPC      (loadPC),
    .illegal     (illegal)
  );

  // Observed (or expected) summary of one instruction, from its first IF
  // cycle up to and including the loadPC cycle.
  typedef struct {
    int         cycles;
    int         ifetch;
    int         loadpc;
    int         pcsrc;
    int         regwrite;
    int         memtoreg;
    int         memread;
    int         memwrite;
    int         overlap;
    int         illegal;
    logic [3:0] alu;
    logic       alusrc;
  } obs_t;

  typedef struct {
    logic [31:0] word;
    logic        zero;
    int          if_delay;
    int          mem_delay;
    bit          chk_alu;
    obs_t        exp;
  } vec_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] rmask;
    int          cls;
    logic [3:0]  alu;
    logic        src;
  } mnem_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic iv, input logic mr,
                       input logic z);
    rst         = r;
    instr_valid = iv;
    mem_ready   = mr;
    Zero        = z;
    @(negedge clk);
  endtask

  // Runs one instruction starting in IF. instr_valid rises after if_delay
  // cycles; mem_ready is held low for mem_delay MEM cycles then pulsed.
  // Inputs the FSM should ignore at a given point are randomised.
  task automatic run_instr(input logic [31:0] word, input logic z,
                           input int if_delay, input int mem_delay,
                           output obs_t o);
    int  mem_start;
    bit  retired;
    mem_start = if_delay + 3;
    o = '{default: 0};
    instr = word;
    rst   = 1'b0;
    for (int k = 0; k < RUN_LIMIT; k++) begin
      if (k < if_delay)       instr_valid = 1'b0;
      else if (k == if_delay) instr_valid = 1'b1;
      else                    instr_valid = 1'($urandom_range(0, 1));
      if (k >= mem_start && k < mem_start + mem_delay) mem_ready = 1'b0;
      else if (k == mem_start + mem_delay)             mem_ready = 1'b1;
      else                                             mem_ready = 1'($urandom_range(0, 1));
      Zero = (k == if_delay + 2) ? z : 1'($urandom_range(0, 1));
      @(negedge clk);
      o.cycles   = k + 1;
      o.ifetch   += int'(ifetch);
      o.pcsrc    += int'(PCSrc);
      o.regwrite += int'(RegWrite);
      o.memtoreg += int'(MemToReg);
      o.memread  += int'(MemRead);
      o.memwrite += int'(MemWrite);
      o.overlap  += int'(MemRead & MemWrite);
      o.illegal  += int'(illegal);
      retired = loadPC;
      if (loadPC) begin
        o.loadpc++;
        o.alu    = ALUCtrl;
        o.alusrc = ALUSrc;
      end
      tick();
      if (retired) break;
    end
  endtask

  task automatic compare(input string tag, input obs_t got, input obs_t exp,
                         input bit chk_alu);
    check($sformatf("%s.cycles", tag),   got.cycles,   exp.cycles);
    check($sformatf("%s.ifetch", tag),   got.ifetch,   exp.ifetch);
    check($sformatf("%s.loadpc", tag),   got.loadpc,   exp.loadpc);
    check($sformatf("%s.pcsrc", tag),    got.pcsrc,    exp.pcsrc);
    check($sformatf("%s.regwrite", tag), got.regwrite, exp.regwrite);
    check($sformatf("%s.memtoreg", tag), got.memtoreg, exp.memtoreg);
    check($sformatf("%s.memread", tag),  got.memread,  exp.memread);
    check($sformatf("%s.memwrite", tag), got.memwrite, exp.memwrite);
    check($sformatf("%s.rdwr_both", tag), got.overlap, exp.overlap);
    check($sformatf("%s.illegal", tag),  got.illegal,  exp.illegal);
    if (chk_alu) begin
      check($sformatf("%s.aluctrl", tag), 32'(got.alu),    32'(exp.alu));
      check($sformatf("%s.alusrc", tag),  32'(got.alusrc), 32'(exp.alusrc));
    end
  endtask

  // Reference model: what one instruction should do, from the class rules.
  function automatic obs_t predict(input int cls, input logic [3:0] alu,
                                   input logic src, input logic z,
                                   input int if_delay, input int mem_delay);
    obs_t e;
    int   lat;
    e = '{default: 0};
    lat = mem_delay + 1;
    if (MAX_WAIT > 0 && lat > MAX_WAIT) lat = MAX_WAIT;
    e.ifetch = if_delay + 1;
    e.loadpc = 1;
    e.alu    = alu;
    e.alusrc = src;
    case (cls)
      C_ALU: begin e.cycles = e.ifetch + 3;       e.regwrite = 1; end
      C_LW:  begin e.cycles = e.ifetch + 3 + lat; e.regwrite = 1;
                   e.memtoreg = 1; e.memread = lat; end
      C_SW:  begin e.cycles = e.ifetch + 2 + lat; e.memwrite = lat; end
      C_BEQ: begin e.cycles = e.ifetch + 2;       e.pcsrc = int'(z); end
      default: e.cycles = e.ifetch + 1;
    endcase
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[$];
    mnem_t mt[$];
    obs_t  got;
    obs_t  exp;
    logic [31:0] rm;
    logic [31:0] im;

    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; mem_ready = 1'b0; Zero = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst.held.loadpc", 32'(loadPC), 32'd0);
    check("rst.held.ifetch", 32'(ifetch), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.ifetch", 32'(ifetch), 32'd1);
    check("rst.others",
          32'({PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, ALUCtrl,
               loadPC, illegal}), 32'd0);
    tick();

    // ---------------- directed table ----------------
    vecs.push_back('{32'h002081B3, 1'b0, 0, 0,  1'b1, '{4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0010, 1'b0}});
    vecs.push_back('{32'h402081B3, 1'b1, 0, 0,  1'b1, '{4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0110, 1'b0}});
    vecs.push_back('{32'h00802283, 1'b0, 0, 3,  1'b1, '{8, 1, 1, 0, 1, 1, 4, 0, 0, 0, 4'b0010, 1'b1}});
    vecs.push_back('{32'h00502223, 1'b0, 1, 0,  1'b1, '{5, 2, 1, 0, 0, 0, 0, 1, 0, 0, 4'b0010, 1'b1}});
    vecs.push_back('{32'h00208463, 1'b1, 0, 0,  1'b1, '{3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0110, 1'b0}});
    vecs.push_back('{32'h00208463, 1'b0, 2, 0,  1'b1, '{5, 3, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 1'b0}});
    vecs.push_back('{32'h00802283, 1'b0, 0, 40, 1'b1, '{20, 1, 1, 0, 1, 1, 16, 0, 0, 0, 4'b0010, 1'b1}});
    vecs.push_back('{32'h00502223, 1'b0, 0, 15, 1'b1, '{19, 1, 1, 0, 0, 0, 0, 16, 0, 0, 4'b0010, 1'b1}});
    vecs.push_back('{32'h4030D093, 1'b0, 2, 0,  1'b1, '{6, 3, 1, 0, 1, 0, 0, 0, 0, 0, 4'b1010, 1'b1}});
    vecs.push_back('{32'h0FF0F093, 1'b0, 1, 0,  1'b1, '{5, 2, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 1'b1}});
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back('{32'h0000007F, 1'b0, 0, 0,  1'b0, '{2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0}});
`endif
    foreach (vecs[i]) begin
      run_instr(vecs[i].word, vecs[i].zero, vecs[i].if_delay,
                vecs[i].mem_delay, got);
      compare($sformatf("vec%0d", i), got, vecs[i].exp, vecs[i].chk_alu);
    end

    // ---------------- rst while a lw sits in MEM ----------------
    instr = 32'h00802283;
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();   // IF
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();   // ID
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();   // EX
    drive(1'b0, 1'b0, 1'b0, 1'b0);           // MEM
    check("rstmem.lw.memread", 32'(MemRead), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("rstmem.lw.commit", 32'({loadPC, RegWrite, MemRead}), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("rstmem.lw.if", 32'({ifetch, RegWrite}), 32'b10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rstmem.lw.stay_if", 32'({ifetch, RegWrite, loadPC}), 32'b100);
    tick();

    // ---------------- rst while a sw completes in MEM ----------------
    instr = 32'h00502223;
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rstmem.sw.memwrite", 32'(MemWrite), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("rstmem.sw.commit", 32'({loadPC, MemWrite, RegWrite}), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rstmem.sw.if", 32'(ifetch), 32'd1);
    tick();

`ifdef ILLEGAL_TRAP_EN
    // ---------------- illegal trap ----------------
    instr = 32'h0000007F;
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("trap.id.loadpc", 32'(loadPC), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      check($sformatf("trap.halt%0d", k),
            32'({illegal, ifetch, loadPC, RegWrite, MemRead, MemWrite}),
            32'b100000);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("trap.cleared", 32'({illegal, ifetch}), 32'b01);
    tick();
`endif

    // ---------------- random instructions vs model ----------------
    rm = 32'h01FF8F80;   // rd, rs1, rs2
    im = 32'hFFFF8F80;   // immediate + registers
    mt.push_back('{32'h00000033, rm, C_ALU, 4'b0010, 1'b0});  // add
    mt.push_back('{32'h40000033, rm, C_ALU, 4'b0110, 1'b0});  // sub
    mt.push_back('{32'h00001033, rm, C_ALU, 4'b1001, 1'b0});  // sll
    mt.push_back('{32'h00002033, rm, C_ALU, 4'b0111, 1'b0});  // slt
    mt.push_back('{32'h00004033, rm, C_ALU, 4'b1101, 1'b0});  // xor
    mt.push_back('{32'h00005033, rm, C_ALU, 4'b1000, 1'b0});  // srl
    mt.push_back('{32'h40005033, rm, C_ALU, 4'b1010, 1'b0});  // sra
    mt.push_back('{32'h00006033, rm, C_ALU, 4'b0001, 1'b0});  // or
    mt.push_back('{32'h00007033, rm, C_ALU, 4'b0000, 1'b0});  // and
    mt.push_back('{32'h00000013, im, C_ALU, 4'b0010, 1'b1});  // addi
    mt.push_back('{32'h00002013, im, C_ALU, 4'b0111, 1'b1});  // slti
    mt.push_back('{32'h00004013, im, C_ALU, 4'b1101, 1'b1});  // xori
    mt.push_back('{32'h00006013, im, C_ALU, 4'b0001, 1'b1});  // ori
    mt.push_back('{32'h00007013, im, C_ALU, 4'b0000, 1'b1});  // andi
    mt.push_back('{32'h00001013, rm, C_ALU, 4'b1001, 1'b1});  // slli
    mt.push_back('{32'h00005013, rm, C_ALU, 4'b1000, 1'b1});  // srli
    mt.push_back('{32'h40005013, rm, C_ALU, 4'b1010, 1'b1});  // srai
    mt.push_back('{32'h00002003, im, C_LW,  4'b0010, 1'b1});  // lw
    mt.push_back('{32'h00002023, im, C_SW,  4'b0010, 1'b1});  // sw
    mt.push_back('{32'h00000063, im, C_BEQ, 4'b0110, 1'b0});  // beq
`ifndef ILLEGAL_TRAP_EN
    mt.push_back('{32'h0000007F, 32'hFFFFFF80, C_BAD, 4'b0000, 1'b0});
    mt.push_back('{32'h02000033, rm, C_BAD, 4'b0000, 1'b0});  // funct7 0x01
    mt.push_back('{32'h40001033, rm, C_BAD, 4'b0000, 1'b0});  // sll, funct7 0x20
    mt.push_back('{32'h00003033, rm, C_BAD, 4'b0000, 1'b0});  // sltu
    mt.push_back('{32'h00003013, im, C_BAD, 4'b0000, 1'b0});  // sltiu
    mt.push_back('{32'h40001013, rm, C_BAD, 4'b0000, 1'b0});  // slli, funct7 0x20
    mt.push_back('{32'h00000003, im, C_BAD, 4'b0000, 1'b0});  // lb
    mt.push_back('{32'h00001063, im, C_BAD, 4'b0000, 1'b0});  // bne
`endif

    for (int n = 0; n < 60; n++) begin
      int          sel;
      int          ifd;
      int          memd;
      logic        z;
      logic [31:0] word;
      sel  = $urandom_range(0, mt.size() - 1);
      ifd  = $urandom_range(0, 3);
      memd = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 22)
                                         : $urandom_range(0, 4);
      z    = 1'($urandom_range(0, 1));
      word = (mt[sel].base & ~mt[sel].rmask) | ($urandom() & mt[sel].rmask);
      exp  = predict(mt[sel].cls, mt[sel].alu, mt[sel].src, z, ifd, memd);
      run_instr(word, z, ifd, memd, got);
      compare($sformatf("rnd%0d_%08h", n, word), got, exp,
              mt[sel].cls != C_BAD);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that sequences the RV32I single-issue datapath through fetch/decode/execute/memory/writeback.
It decodes the current instruction word and drives every datapath control strobe: PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC.
It also handshakes with instruction and data memory.
It sits beside the datapath inside the processor top level.

Parameters:
MEM_WAIT_MAX, 16, max cycles spent in MEM waiting for mem_ready before forcing progress; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
instr  input  32  current instruction word, held stable by fetch logic from ID until next IF
instr_valid  input  1  instruction memory returned instr this cycle
mem_ready  input  1  data memory completed read/write this cycle
Zero  input  1  ALU zero flag from datapath
ifetch  output  1  instruction fetch request
PCSrc  output  1  select branch target on PC update
ALUSrc  output  1  ALU op2 = immediate
RegWrite  output  1  register file write enable
MemToReg  output  1  writeback from data memory
MemRead  output  1  data memory read strobe
MemWrite  output  1  data memory write strobe
ALUCtrl  output  4  ALU operation
loadPC  output  1  one-cycle PC update pulse
illegal  output  1  sticky illegal-instruction flag (0 unless ILLEGAL_TRAP_EN)

Behaviour:
- State register: IF, ID, EX, MEM, WB, HALT. Outputs are combinational from state and instr.
- Reset: state=IF; all outputs 0 except ifetch=1 in IF; illegal=0; wait counter=0.
- rst in any state aborts the in-flight instruction, with no loadPC, RegWrite or MemWrite in that cycle.
- IF: ifetch=1. Stay while instr_valid=0; go to ID when instr_valid=1.
- ID: decode opcode[6:0], funct3, funct7[5]. Single cycle, then EX.
- Supported opcodes: R 0110011 (add, sub, and, or, xor, slt, sll, srl, sra); I-ALU 0010011 (addi, andi, ori, xori, slti, slli, srli, srai); LW 0000011; SW 0100011; BEQ 1100011.
- EX: ALUSrc=1 for I-ALU/LW/SW, 0 otherwise. ALUCtrl is decoded from funct3/funct7; ADD for LW/SW; SUB for BEQ.
- EX transitions: R and I-ALU go to WB; LW/SW go to MEM; BEQ goes to IF with loadPC=1 and PCSrc=Zero.
- ALUSrc and ALUCtrl hold their EX values through MEM and WB so the data address and result stay stable.
- MEM: MemRead=1 (LW) or MemWrite=1 (SW). Stay until mem_ready=1.
- MEM exit: LW goes to WB; SW goes to IF with loadPC=1 in the completing cycle.
- MEM timeout: if MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX, leave MEM as if mem_ready had arrived. The counter clears on MEM entry.
- WB: RegWrite=1; MemToReg=1 for LW. loadPC=1, PCSrc=0, then go to IF.
- Cycle counts (with instr_valid/mem_ready immediate): R/I 4, LW 5, SW 4, BEQ 3.
- Sub-encodings outside the listed set (e.g. R-type funct7 other than 0x00/0x20) are treated as unsupported.
- loadPC is asserted exactly once per retired instruction. PCSrc=1 only in BEQ EX with Zero=1.
- MemRead and MemWrite are never asserted together.
- srai/srli are distinguished by instr[30]; sub/add by instr[30] with R opcode only.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in ID sets illegal=1 and moves to HALT. HALT holds all strobes at 0 until rst.
- Undefined: an unsupported opcode retires as a NOP: ID asserts loadPC (PCSrc=0) and returns to IF. There is no HALT state and illegal is tied 0.

Decomposition:
- Package ctrl_pkg holds:
  - State encodings.
  - Opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ).
  - ALUCtrl encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- Sub-module alu_decoder (combinational): opcode/funct3/funct7[5] in, ALUCtrl and an unsupported flag out. The FSM instantiates it once.

Test Plan:
- rst, then instr=0x002081B3 (add x3,x1,x2) with instr_valid=1 -> states IF,ID,EX,WB. ALUCtrl=0010, ALUSrc=0, RegWrite=1 in WB only, loadPC pulse in WB, 4 cycles.
- instr=0x402081B3 (sub), then 0x00802283 (lw x5,8(x0)) with mem_ready delayed 3 cycles -> sub gives ALUCtrl=0110. lw holds MemRead=1 for 4 MEM cycles, then WB with MemToReg=1 and RegWrite=1.
- instr=0x00502223 (sw x5,4(x0)) -> MemWrite=1 in MEM, RegWrite never 1, loadPC in the mem_ready cycle, return to IF.
- instr=0x00208463 (beq) with Zero=1 -> EX asserts loadPC=1 and PCSrc=1. Repeat with Zero=0 -> loadPC=1, PCSrc=0, 3 cycles total.
- lw with mem_ready held 0 and MEM_WAIT_MAX=16 -> MEM exits after 16 cycles. Assert rst in MEM on a second lw -> next state IF, no RegWrite issued.
- instr=0x0000007F -> with ILLEGAL_TRAP_EN: illegal=1, HALT, no loadPC until rst. Without: NOP, one loadPC pulse in ID.
